// File: rtl/div_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// div_sequencer_pkg
// Shared ALU opcode constants used by the control unit, the single-cycle ALU
// and the multi-cycle divide sequencer, plus the divide FSM state encoding.
// ---------------------------------------------------------------------------
package div_sequencer_pkg;

  // Single-cycle ALU opcodes
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLL  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_SLT  = 5'b01000;
  localparam logic [4:0] ALU_SLTU = 5'b01001;

  // Multi-cycle divide/remainder opcodes. bit0 = unsigned, bit1 = remainder.
  localparam logic [4:0] ALU_DIV  = 5'b01100;
  localparam logic [4:0] ALU_DIVU = 5'b01101;
  localparam logic [4:0] ALU_REM  = 5'b01110;
  localparam logic [4:0] ALU_REMU = 5'b01111;

  // Upper opcode bits shared by all four divide/remainder codes
  localparam logic [2:0] ALU_MDIV_GRP = 3'b011;

  // Divide sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  // True when the opcode belongs to the divide/remainder group
  function automatic logic is_div_op(input logic [4:0] op);
    is_div_op = (op[4:2] == ALU_MDIV_GRP);
  endfunction

endpackage

// File: rtl/div_sequencer_step.sv
// ---------------------------------------------------------------------------
// div_sequencer_step (module div_step)
// One combinational radix-2 restoring division step.
//   rem_in   : partial remainder (always < divisor on entry)
//   next_bit : next dividend bit shifted in from the quotient register
//   divisor  : divisor magnitude
//   rem_out  : updated partial remainder
//   quo_bit  : quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            next_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            quo_bit
);

  logic [XLEN:0]   shifted_s;
  logic [XLEN-1:0] diff_s;

  // Trial subtraction: keep the difference when the shifted remainder covers
  // the divisor. The kept difference always fits in XLEN bits because the
  // incoming remainder is below the divisor, so a modular subtract suffices.
  always_comb begin
    shifted_s = {rem_in, next_bit};
    diff_s    = shifted_s[XLEN-1:0] - divisor;
    quo_bit   = (shifted_s >= {1'b0, divisor});
    if (quo_bit) begin
      rem_out = diff_s;
    end else begin
      rem_out = shifted_s[XLEN-1:0];
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit sitting beside the EX-stage ALU.
// Runs an XLEN-step restoring division on operand magnitudes, then applies
// sign correction. Divide-by-zero and signed overflow finish immediately.
// Ports:
//   CLK          : clock, rising edge
//   RESET        : asynchronous active-low reset
//   start        : EX-stage instruction valid
//   aluop        : ALU opcode from the control unit
//   operand_a    : dividend (rs1)
//   operand_b    : divisor (rs2)
//   flush        : pipeline flush, aborts any operation in progress
//   stall        : holds IF/ID/EX while a divide is pending (combinational)
//   result       : quotient or remainder, held until the next result
//   result_valid : one-cycle pulse marking a fresh result
// ---------------------------------------------------------------------------
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [4:0]      aluop,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  ZERO_V   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES_V   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MIN_V    = {1'b1, {(XLEN-1){1'b0}}};

  // Two's-complement negate when neg is set
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            neg);
    if (neg) begin
      cond_neg = ~v + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      cond_neg = v;
    end
  endfunction

  div_state_t      state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0] rem_r, quo_r, dvsr_r, result_r;
  logic            q_neg_r, r_neg_r, is_rem_r, result_valid_r;

  logic            is_div_s, signed_s, rem_op_s, sa_s, sb_s, div0_s, ovf_s;
  logic [XLEN-1:0] mag_a_s, mag_b_s;
  logic [XLEN-1:0] step_rem_s;
  logic            step_q_s;

  // Decode of the issuing instruction and its operands at acceptance
  always_comb begin
    is_div_s = start & is_div_op(aluop);
    signed_s = ~aluop[0];
    rem_op_s = aluop[1];
    sa_s     = signed_s & operand_a[XLEN-1];
    sb_s     = signed_s & operand_b[XLEN-1];
    mag_a_s  = cond_neg(operand_a, sa_s);
    mag_b_s  = cond_neg(operand_b, sb_s);
    div0_s   = (operand_b == ZERO_V);
    ovf_s    = signed_s & (operand_a == MIN_V) & (operand_b == ONES_V);
  end

  // Single restoring step; the next dividend bit is the quotient register MSB
  div_step #(.XLEN(XLEN)) u_step (
    .rem_in   (rem_r),
    .next_bit (quo_r[XLEN-1]),
    .divisor  (dvsr_r),
    .rem_out  (step_rem_s),
    .quo_bit  (step_q_s)
  );

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          next_state_s = ST_IDLE;
        end else if (is_div_s) begin
          if (div0_s | ovf_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_CALC;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush) begin
          next_state_s = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = ST_FIX;
        end else begin
          next_state_s = ST_CALC;
        end
      end
      ST_FIX: begin
        if (flush) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath: operand latch, iteration, sign fix-up and result capture
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_r    <= {CNT_W{1'b0}};
      rem_r    <= ZERO_V;
      quo_r    <= ZERO_V;
      dvsr_r   <= ZERO_V;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      is_rem_r <= 1'b0;
      result_r <= ZERO_V;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!flush && is_div_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            rem_r    <= ZERO_V;
            quo_r    <= mag_a_s;
            dvsr_r   <= mag_b_s;
            q_neg_r  <= sa_s ^ sb_s;
            r_neg_r  <= sa_s;
            is_rem_r <= rem_op_s;
            // Special cases resolve here and skip the iteration entirely
            if (div0_s) begin
              result_r <= rem_op_s ? operand_a : ONES_V;
            end else if (ovf_s) begin
              result_r <= rem_op_s ? ZERO_V : MIN_V;
            end
          end
        end
        ST_CALC: begin
          rem_r <= step_rem_s;
          quo_r <= {quo_r[XLEN-2:0], step_q_s};
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        ST_FIX: begin
          if (!flush) begin
            result_r <= is_rem_r ? cond_neg(rem_r, r_neg_r)
                                 : cond_neg(quo_r, q_neg_r);
          end
        end
        ST_DONE: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Result-valid pulse is registered high for the single DONE cycle
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      result_valid_r <= 1'b0;
    end else begin
      result_valid_r <= (next_state_s == ST_DONE);
    end
  end

  // Stall covers the issue cycle and every cycle up to, not including, DONE
  always_comb begin
    stall = RESET & (((state_r == ST_IDLE) & is_div_s & ~flush) |
                     (state_r == ST_CALC) | (state_r == ST_FIX));
  end

  assign result       = result_r;
  assign result_valid = result_valid_r;

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller and datapath for the RV32M divide/remainder ops: DIV 01100, DIVU 01101, REM 01110, REMU 01111.
- Sits beside the single-cycle ALU in EX.
- Accepts an issue from the decoded ALU opcode, runs a radix-2 restoring division, and holds the pipeline with a stall until the result is ready.
- Results follow the RISC-V M-extension rules for divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand/result width; must be a power of two ≥ 8.
- CNT_W, $clog2(XLEN), iteration counter width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- start  input  1  EX-stage instruction valid this cycle.
- aluop  input  5  ALU opcode from the control unit.
- operand_a  input  XLEN  dividend (rs1).
- operand_b  input  XLEN  divisor (rs2).
- flush  input  1  pipeline flush; aborts any operation in progress.
- stall  output  1  holds IF/ID/EX while a divide is pending.
- result  output  XLEN  quotient or remainder.
- result_valid  output  1  one-cycle pulse; result is valid.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE; result=0; result_valid=0; counter, remainder, quotient and sign flags cleared. Registered outputs read 0 while reset is held. stall reads 0 while reset is held, because IDLE with no accepted start drives it low.
- is_div = start & (aluop[4:2]==3'b011). Any other aluop is ignored.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If flush, stay in IDLE.
  - Else if is_div:
    - Latch op type (signed = ~aluop[0]; rem = aluop[1]).
    - Latch operand magnitudes: negate if signed and MSB is set.
    - Latch sign flags: quotient negative = sa^sb; remainder negative = sa.
    - Special case, divisor==0: go to DONE with quotient 0xFFFF_FFFF or remainder = raw operand_a.
    - Special case, signed and a==0x8000_0000 and b==0xFFFF_FFFF: go to DONE with quotient 0x8000_0000 or remainder 0.
    - Otherwise: go to CALC with counter=0.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by 1; trial = {rem[XLEN-1:0], quo_msb} − divisor, XLEN+1 bits.
  - If trial is non-negative, rem=trial and quo LSB=1; else quo LSB=0.
  - After XLEN steps (counter==XLEN-1), go to FIX.
- FIX: apply sign correction (two's-complement negate per flag) and select quotient or remainder into the result register; go to DONE.
- DONE: result_valid=1 for exactly this cycle; go to IDLE. A start seen in DONE is ignored.
- result holds its value after DONE until the next result is written.
- stall = (IDLE & is_div & ~flush) | CALC | FIX. It is combinational and low in DONE, so the stalled instruction advances in the same cycle that result_valid is high.
- Latency, with acceptance on edge N:
  - Normal case: result_valid high in the cycle after edge N+XLEN+1, i.e. 34 cycles of stall for XLEN=32.
  - Special cases: result_valid high in the cycle after edge N, i.e. 1 cycle of stall.
- flush in CALC/FIX: go to IDLE on the next edge; no result_valid; result unchanged. flush in DONE: pulse still occurs; the pipeline discards it. flush and start in the same cycle: flush wins.
- Reset mid-operation: immediate abort to reset values; no pulse.
- Operands are sampled only at acceptance. Input changes during CALC have no effect.

Decomposition:
- Shared include/package: ALU opcode constants (ALU_DIV=5'b01100, ALU_DIVU, ALU_REM, ALU_REMU, plus the existing ALU codes) and the state encoding localparams. The control unit and ALU use the same constants.
- One sub-module, div_step: a combinational single restoring step. Inputs are partial remainder, next dividend bit and divisor; outputs are the new remainder and the quotient bit. It is instantiated once in CALC.

Test Plan:
- DIVU 100/7: stall high for 34 cycles, then result_valid pulse with result=14. Repeat as REMU: result=2.
- DIV −20/3 (0xFFFF_FFEC, 3): result=0xFFFF_FFFA (−6). Repeat as REM: result=0xFFFF_FFFE (−2).
- DIV 5/0: result=0xFFFF_FFFF after a 1-cycle stall. REMU 5/0: result=5. DIV 0x8000_0000/0xFFFF_FFFF: result=0x8000_0000. REM of the same operands: result=0.
- Non-divide aluop=00000 with start=1: stall stays 0, result_valid never asserts, state stays IDLE.
- Start DIVU 1000/10 and assert flush at cycle 10: state back to IDLE on the next edge, no result_valid, stall low. A fresh DIVU 9/3 then completes with result=3.
- Pull RESET low asynchronously mid-CALC: outputs read 0 immediately. After release, a REM 7/2 gives result=1 with normal latency.
